// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks DEPTH in-flight destination tags,
// picks the youngest producer per source operand and flags non-forwardable loads.

module fwd_lookup #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 3,
  parameter int SEL_W     = 2,
  parameter int LOAD_SLOT = 1
) (
  input  logic [DEPTH-1:0]             slot_vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] slot_dest,
  input  logic [DEPTH-1:0]             slot_load,
  input  logic [ADDR_W-1:0]            src,
  output logic [SEL_W-1:0]             sel,
  output logic                         hazard
);
  logic found;

  // Scan from youngest; the first match decides, even if it cannot forward.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && slot_vld[k] && (slot_dest[k] != '0) && (slot_dest[k] == src)) begin
        found = 1'b1;
        if (!slot_load[k] || (k >= LOAD_SLOT))
          sel = SEL_W'(k + 1);
        else
          hazard = 1'b1;
      end
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 3,
  parameter int NUM_SRC   = 2,
  parameter int SEL_W     = 2,
  parameter int LOAD_SLOT = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic                      issue_wr_en,
  input  logic [ADDR_W-1:0]         issue_dest,
  input  logic                      issue_is_load,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      flush,
  input  logic                      hold,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);
  logic [DEPTH-1:0]                vld_pipe;
  logic [DEPTH-1:0][ADDR_W-1:0]    dest_pipe;
  logic [DEPTH-1:0]                load_pipe;
  logic [NUM_SRC-1:0][ADDR_W-1:0]  src_arr;
  logic [NUM_SRC-1:0][SEL_W-1:0]   sel_arr;
  logic [NUM_SRC-1:0]              hazard;

  assign src_arr = src_addr;
  assign fwd_sel = sel_arr;
  assign stall   = |hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_lookup #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W), .LOAD_SLOT(LOAD_SLOT)
    ) u_lookup (
      .slot_vld (vld_pipe),
      .slot_dest(dest_pipe),
      .slot_load(load_pipe),
      .src      (src_arr[i]),
      .sel      (sel_arr[i]),
      .hazard   (hazard[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      dest_pipe <= '0;
      load_pipe <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        dest_pipe[k] <= dest_pipe[k-1];
        load_pipe[k] <= load_pipe[k-1];
      end
      // Flush and stall both inject exactly one bubble at slot 0.
      if (flush || stall) begin
        vld_pipe[0]  <= 1'b0;
        dest_pipe[0] <= '0;
        load_pipe[0] <= 1'b0;
      end else begin
        vld_pipe[0]  <= issue_valid & issue_wr_en;
        dest_pipe[0] <= issue_dest;
        load_pipe[0] <= issue_is_load;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_fwd_scoreboard;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             issue_valid = 1'b0, issue_wr_en = 1'b0, issue_is_load = 1'b0;
  logic [ADDR_W-1:0] issue_dest = '0;
  logic [2*ADDR_W-1:0] src_addr = {5'd5, 5'd5};
  logic             flush = 1'b0, hold = 1'b0;
  logic [3:0]       fwd_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  fwd_scoreboard #(
    .ADDR_W(ADDR_W), .DEPTH(3), .NUM_SRC(2), .SEL_W(2), .LOAD_SLOT(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load), .src_addr(src_addr),
    .flush(flush), .hold(hold), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       sel;
    logic             st;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests += 3;
      if (fwd_sel !== e.sel) begin
        n_fail++;
        $display("FAIL %s fwd_sel got %h want %h", e.name, fwd_sel, e.sel);
      end
      if (stall !== e.st) begin
        n_fail++;
        $display("FAIL %s stall got %b want %b", e.name, stall, e.st);
      end
      if (stall_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s stall_cnt got %0d want %0d", e.name, stall_cnt, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
  task automatic step(input logic r, v, wr, input logic [4:0] d, input logic ld,
                      input logic [4:0] s0, s1, input logic fl, hd,
                      input logic [1:0] e0, e1, input logic est,
                      input logic [CNT_W-1:0] ecnt, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; issue_valid = v; issue_wr_en = wr; issue_dest = d; issue_is_load = ld;
    src_addr = {s1, s0}; flush = fl; hold = hd;
    e.sel = {e1, e0}; e.st = est; e.cnt = ecnt; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    int cnt;
    //    r  v  wr dest ld s0 s1 fl hd  e0 e1 st cnt
    step(1, 1, 1, 5'd5, 0, 5, 5, 0, 0,  0, 0, 0, 0, "reset");
    step(0, 0, 0, 5'd0, 0, 5, 5, 0, 0,  0, 0, 0, 0, "reset_release");
    // ALU chain
    step(0, 1, 1, 5'd8, 0, 8, 0, 0, 0,  0, 0, 0, 0, "alu_issue");
    step(0, 0, 0, 5'd0, 0, 8, 0, 0, 0,  1, 0, 0, 0, "alu_slot0");
    step(0, 0, 0, 5'd0, 0, 8, 0, 0, 0,  2, 0, 0, 0, "alu_slot1");
    step(0, 0, 0, 5'd0, 0, 8, 0, 0, 0,  3, 0, 0, 0, "alu_slot2");
    step(0, 0, 0, 5'd0, 0, 8, 0, 0, 0,  0, 0, 0, 0, "alu_gone");
    // Load-use
    step(0, 1, 1, 5'd9, 1, 0, 0, 0, 0,  0, 0, 0, 0, "load_issue");
    step(0, 1, 1, 5'd3, 0, 0, 9, 0, 0,  0, 0, 1, 0, "load_use_stall");
    step(0, 1, 1, 5'd3, 0, 0, 9, 0, 0,  0, 2, 0, 1, "load_use_fwd");
    // Priority and register zero
    step(0, 1, 1, 5'd4, 0, 0, 0, 0, 0,  0, 0, 0, 1, "prio_issue_a");
    step(0, 1, 1, 5'd4, 0, 4, 0, 0, 0,  1, 0, 0, 1, "prio_one_4");
    step(0, 1, 1, 5'd6, 0, 4, 0, 0, 0,  1, 0, 0, 1, "prio_youngest");
    step(0, 1, 1, 5'd6, 1, 6, 4, 0, 0,  1, 2, 0, 1, "prio_two_ops");
    step(0, 1, 1, 5'd0, 0, 6, 0, 0, 0,  0, 0, 1, 1, "young_load_wins");
    step(0, 1, 1, 5'd0, 0, 6, 0, 0, 0,  2, 0, 0, 2, "load_slot1_fwd");
    step(0, 0, 0, 5'd0, 0, 0, 6, 0, 0,  0, 3, 0, 2, "reg_zero");
    // Hold during stall
    step(0, 1, 1, 5'd9, 1, 0, 0, 0, 0,  0, 0, 0, 2, "hold_load");
    step(0, 0, 0, 5'd0, 0, 9, 0, 0, 1,  0, 0, 1, 2, "hold_1");
    step(0, 0, 0, 5'd0, 0, 9, 0, 0, 1,  0, 0, 1, 2, "hold_2");
    step(0, 0, 0, 5'd0, 0, 9, 0, 0, 1,  0, 0, 1, 2, "hold_3");
    step(0, 0, 0, 5'd0, 0, 9, 0, 0, 0,  0, 0, 1, 2, "hold_release");
    step(0, 0, 0, 5'd0, 0, 9, 0, 0, 0,  2, 0, 0, 3, "hold_after");
    // Flush squashes the issuing producer
    step(0, 1, 1, 5'd10, 0, 0, 0, 1, 0, 0, 0, 0, 3, "flush_issue");
    step(0, 0, 0, 5'd0, 0, 10, 0, 0, 0, 0, 0, 0, 3, "flush_squashed");
    // Saturation: a stall every other cycle, 20 times
    cnt = 3;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0, CNT_W'(cnt), "sat_load");
      step(0, 0, 0, 5'd0, 0, 9, 0, 0, 0, 0, 0, 1, CNT_W'(cnt), "sat_stall");
      if (cnt < 15) cnt++;
    end
    step(0, 0, 0, 5'd0, 0, 0, 0, 0, 0,  0, 0, 0, 15, "sat_final");
    // Async reset with full slots and an active stall
    step(0, 1, 1, 5'd7, 0, 0, 0, 0, 0,  0, 0, 0, 15, "fill_7");
    step(0, 1, 1, 5'd8, 0, 0, 0, 0, 0,  0, 0, 0, 15, "fill_8");
    step(0, 1, 1, 5'd9, 1, 0, 0, 0, 0,  0, 0, 0, 15, "fill_9");
    step(0, 0, 0, 5'd0, 0, 9, 7, 0, 1,  0, 3, 1, 15, "full_stall");
    step(1, 0, 0, 5'd0, 0, 9, 7, 0, 1,  0, 0, 0, 0, "async_rst");
    step(0, 0, 0, 5'd0, 0, 9, 7, 0, 0,  0, 0, 0, 0, "post_rst_a");
    step(0, 0, 0, 5'd0, 0, 9, 8, 0, 0,  0, 0, 0, 0, "post_rst_b");

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
